// File: rtl/frame_buffer_ctrl.sv
// ---------------------------------------------------------------------------
// frame_buffer_ctrl
//   Ping-pong frame store controller sitting between the host pixel stream
//   and the LED driver. Two frame banks live in one external RAM; the bank
//   is selected by the RAM address MSB. The host always fills the back bank,
//   the driver always reads the front bank, and the banks swap only on a
//   driver latch request after a complete frame has been written, so the
//   driver never displays a torn frame.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_wr_data/valid/sof     host beat (one channel sample), sof marks ch 0
//   o_wr_ready              beat accepted this cycle when valid & ready
//   i_drv_addr, i_drv_read  driver read address / enable (zero latency)
//   i_drv_drq               driver latch strobe, rising edge requests swap
//   o_ram_raddr, o_ram_re   RAM read port {front bank, i_drv_addr}
//   o_ram_waddr/wdata/we    RAM write port {back bank, ptr}, registered
//   o_bank                  current front bank
//   o_swap                  one-cycle pulse when the banks swap
//   o_err_short             one-cycle pulse when an early SOF aborts a frame
//   o_swap_count            wrapping count of swaps since reset
// ---------------------------------------------------------------------------
module frame_buffer_ctrl #(
  parameter int c_ledboards = 30,
  parameter int c_channels  = c_ledboards * 32,
  parameter int c_addr_w    = $clog2(c_channels),
  parameter int c_bps       = 12,
  parameter int c_cnt_w     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [c_bps-1:0]    i_wr_data,
  input  logic                i_wr_valid,
  input  logic                i_wr_sof,
  output logic                o_wr_ready,
  input  logic [c_addr_w-1:0] i_drv_addr,
  input  logic                i_drv_read,
  input  logic                i_drv_drq,
  output logic [c_addr_w:0]   o_ram_raddr,
  output logic                o_ram_re,
  output logic [c_addr_w:0]   o_ram_waddr,
  output logic [c_bps-1:0]    o_ram_wdata,
  output logic                o_ram_we,
  output logic                o_bank,
  output logic                o_swap,
  output logic                o_err_short,
  output logic [c_cnt_w-1:0]  o_swap_count
);

  typedef enum logic [1:0] {
    s_idle = 2'd0,
    s_fill = 2'd1,
    s_full = 2'd2
  } state_t;

  localparam logic [c_addr_w-1:0] c_ptr_zero = '0;
  localparam logic [c_addr_w-1:0] c_ptr_one  = c_addr_w'(1);
  localparam logic [c_addr_w-1:0] c_ptr_last = c_addr_w'(c_channels - 1);
  localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);

  state_t                state_q,   state_d;
  logic [c_addr_w-1:0]   ptr_q,     ptr_d;
  logic                  pending_q, pending_d;
  logic                  bank_q,    bank_d;
  logic                  drq_q;
  logic                  we_q,      we_d;
  logic [c_addr_w:0]     waddr_q,   waddr_d;
  logic [c_bps-1:0]      wdata_q,   wdata_d;
  logic                  swap_q,    swap_d;
  logic                  err_q,     err_d;
  logic [c_cnt_w-1:0]    cnt_q,     cnt_d;

  logic                  wr_ready_s;
  logic                  accept_s;
  logic                  drq_rise_s;

  assign accept_s   = i_wr_valid & wr_ready_s;
  assign drq_rise_s = i_drv_drq & ~drq_q;

  // State register: FSM state, write pointer, bank, and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= s_idle;
      ptr_q     <= c_ptr_zero;
      pending_q <= 1'b0;
      bank_q    <= 1'b0;
      drq_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      swap_q    <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      bank_q    <= bank_d;
      drq_q     <= i_drv_drq;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      swap_q    <= swap_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic: write FSM plus the swap request that overrides it.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    bank_d    = bank_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    swap_d    = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      s_idle: begin
        // Without an SOF the beat's position is unknown, so it is dropped.
        if (accept_s && i_wr_sof) begin
          we_d    = 1'b1;
          waddr_d = {~bank_q, c_ptr_zero};
          wdata_d = i_wr_data;
          if (c_channels == 1) begin
            state_d   = s_full;
            pending_d = 1'b1;
            ptr_d     = c_ptr_zero;
          end else begin
            state_d = s_fill;
            ptr_d   = c_ptr_one;
          end
        end else begin
          state_d = s_idle;
        end
      end

      s_fill: begin
        if (accept_s) begin
          we_d    = 1'b1;
          wdata_d = i_wr_data;
          if (i_wr_sof) begin
            // Early SOF: restart the frame in place, flag the short frame.
            err_d   = 1'b1;
            waddr_d = {~bank_q, c_ptr_zero};
            ptr_d   = c_ptr_one;
          end else begin
            waddr_d = {~bank_q, ptr_q};
            if (ptr_q == c_ptr_last) begin
              state_d   = s_full;
              pending_d = 1'b1;
              ptr_d     = c_ptr_zero;
            end else begin
              ptr_d = ptr_q + c_ptr_one;
            end
          end
        end else begin
          state_d = s_fill;
        end
      end

      s_full: begin
        state_d = s_full;
      end

      default: begin
        state_d   = s_idle;
        ptr_d     = c_ptr_zero;
        pending_d = 1'b0;
      end
    endcase

    // pending is only ever set on entry to s_full, so a swap never races
    // with an accepted beat and the back bank stays consistent.
    if (drq_rise_s && pending_q) begin
      bank_d    = ~bank_q;
      pending_d = 1'b0;
      state_d   = s_idle;
      swap_d    = 1'b1;
      cnt_d     = cnt_q + c_cnt_one;
    end else begin
      swap_d = 1'b0;
    end
  end

  // Output logic: ready from state, read path is pure pass-through.
  always_comb begin
    wr_ready_s  = (state_q != s_full);
    o_wr_ready  = wr_ready_s;
    o_ram_raddr = {bank_q, i_drv_addr};
    o_ram_re    = i_drv_read;
  end

  assign o_ram_we     = we_q;
  assign o_ram_waddr  = waddr_q;
  assign o_ram_wdata  = wdata_q;
  assign o_bank       = bank_q;
  assign o_swap       = swap_q;
  assign o_err_short  = err_q;
  assign o_swap_count = cnt_q;

endmodule
